// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, datapath widths, the PC step and
// the NOP that fills a flushed IF/ID slot.
package core_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0]   PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Drops the byte-offset bits so a target always lands on a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: valid/ready slot carrying one instruction and its
// PC, with a flush that beats both a new load and a same-cycle drain.
module if_id_reg
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              flush,
  input  logic              ready,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc_in,
  output logic              valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc,
  output logic              slot_free
);

  logic              valid_reg, valid_next;
  logic [INST_W-1:0] inst_reg, inst_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic              fire;

  assign fire      = valid_reg & ready;
  assign slot_free = ~valid_reg | fire;

  always_comb begin
    valid_next = valid_reg;
    inst_next  = inst_reg;
    pc_next    = pc_reg;
    if (flush) begin
      valid_next = 1'b0;
      inst_next  = NOP_INST;
    end else if (load) begin
      valid_next = 1'b1;
      inst_next  = inst_in;
      pc_next    = pc_in;
    end else if (fire) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      inst_reg  <= '0;
      pc_reg    <= '0;
    end else begin
      valid_reg <= valid_next;
      inst_reg  <= inst_next;
      pc_reg    <= pc_next;
    end
  end

  assign valid = valid_reg;
  assign inst  = inst_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/HALT FSM, drives the
// instruction-memory word address, and feeds the IF/ID slot.
// Optional misaligned-redirect trap: define FETCH_ALIGN_CHK_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              ADDR_W   = 6,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_inst_i,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [PC_W-1:0]   id_pc_o,
  output logic [PC_W-1:0]   id_pc4_o,
  output logic              halted_o,
  output logic              misalign_o
);

  fetch_state_t    state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic            load, flush, slot_free, in_range;

  // Anything above the memory's byte span means we have run off the end.
  assign in_range    = (pc_reg[PC_W-1:ADDR_W+2] == '0);
  assign imem_addr_o = pc_reg[ADDR_W+1:2];

`ifdef FETCH_ALIGN_CHK_EN
  logic misalign_reg, misalign_next;
  logic bad_target;

  assign bad_target = (redirect_pc_i[1:0] != 2'b00);
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    load       = 1'b0;
    flush      = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    misalign_next = misalign_reg;
`endif
    if (redirect_i) begin
      // Redirect always flushes; the target is fetched on the following cycle.
      flush = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
      if (bad_target) begin
        misalign_next = 1'b1;
        state_next    = HALT;
      end else begin
        pc_next    = redirect_pc_i;
        state_next = RUN;
      end
`else
      pc_next    = word_align(redirect_pc_i);
      state_next = RUN;
`endif
    end else begin
      unique case (state_reg)
        BOOT: state_next = RUN;
        RUN: begin
          if (!in_range) begin
            state_next = HALT;
          end else if (slot_free) begin
            load    = 1'b1;
            pc_next = pc_reg + PC_STEP;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = HALT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end

  assign misalign_o = misalign_reg;
`else
  assign misalign_o = 1'b0;
`endif

  if_id_reg u_if_id (
    .clk       (clk_i),
    .srst      (rst_i),
    .load      (load),
    .flush     (flush),
    .ready     (id_ready_i),
    .inst_in   (imem_inst_i),
    .pc_in     (pc_reg),
    .valid     (id_valid_o),
    .inst      (id_inst_o),
    .pc        (id_pc_o),
    .slot_free (slot_free)
  );

  assign id_pc4_o = id_pc_o + PC_STEP;
  assign halted_o = (state_reg == HALT);

endmodule
